// File: rtl/bcd_to_binary_pkg.sv
// Shared constants and types for the BCD-to-binary converter.
package bcd_to_binary_pkg;

  // Converter control states
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Default geometry: three digits into a 10-bit result, 8-bit score ceiling
  localparam int unsigned NDigitsDef  = 3;
  localparam int unsigned BinWDef     = 10;
  localparam int unsigned ScoreMaxDef = 255;

  // Largest legal value of a single BCD digit
  localparam int unsigned DigitMax = 9;

endpackage

// File: rtl/bcd_to_binary_if.sv
// Start/done handshake and data bundle between a digit source and the converter.
interface bcd_to_binary_if #(
  parameter int unsigned N_DIGITS = 3,
  parameter int unsigned BIN_W    = 10
);

  logic                  start;
  logic [4*N_DIGITS-1:0] bcd;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      binary;
  logic                  invalid;
  logic                  overflow;

  modport master (
    output start, bcd,
    input  busy, done, binary, invalid, overflow
  );

  modport slave (
    input  start, bcd,
    output busy, done, binary, invalid, overflow
  );

endinterface

// File: rtl/bcd_to_binary_nibble_adjust.sv
// One reverse double-dabble correction: a nibble >= 8 after the shift loses 3.
module bcd_nibble_adjust (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  // Bit 3 set means the nibble is at least 8, so the subtract never wraps
  always_comb begin
    nib_o = nib_i;
    if (nib_i[3]) begin
      nib_o = nib_i - 4'd3;
    end
  end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per clock.
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int unsigned N_DIGITS  = NDigitsDef,
  parameter int unsigned BIN_W     = BinWDef,
  parameter int unsigned SCORE_MAX = ScoreMaxDef
) (
  input logic            clk,
  input logic            rst_n,
  bcd_to_binary_if.slave bus
);

  localparam int unsigned BcdW  = 4 * N_DIGITS;
  localparam int unsigned WorkW = BcdW + BIN_W;
  localparam int unsigned CntW  = $clog2(BIN_W + 1);

  state_e             state_q, state_d;
  logic [WorkW-1:0]   work_q, work_d;
  logic [WorkW-1:0]   work_shr, work_step;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0]   binary_q, binary_d;
  logic               invalid_q, invalid_d;
  logic               overflow_q, overflow_d;
  logic               any_bad;
  logic               last_step;

  // Flag any digit of the presented input above 9
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (bus.bcd[4*i +: 4] > 4'(DigitMax)) begin
        any_bad = 1'b1;
      end
    end
  end

  // One conversion step: shift the {bcd_part, bin_part} register right, then fix each digit
  assign work_shr = work_q >> 1;
  assign work_step[BIN_W-1:0] = work_shr[BIN_W-1:0];

  for (genvar g = 0; g < int'(N_DIGITS); g++) begin : gen_adj
    bcd_nibble_adjust u_adj (
      .nib_i (work_shr[BIN_W + 4*g +: 4]),
      .nib_o (work_step[BIN_W + 4*g +: 4])
    );
  end

  assign last_step = (cnt_q == CntW'(BIN_W - 1));

  // Next-state, datapath and result update
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    binary_d   = binary_q;
    invalid_d  = invalid_q;
    overflow_d = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (any_bad) begin
            binary_d   = '0;
            invalid_d  = 1'b1;
            overflow_d = 1'b0;
            state_d    = StDone;
          end else begin
            work_d    = {bus.bcd, {BIN_W{1'b0}}};
            cnt_d     = '0;
            invalid_d = 1'b0;
            state_d   = StShift;
          end
        end
      end
      StShift: begin
        work_d = work_step;
        cnt_d  = cnt_q + 1'b1;
        if (last_step) begin
          binary_d   = work_step[BIN_W-1:0];
          overflow_d = (work_step[BIN_W-1:0] > BIN_W'(SCORE_MAX));
          state_d    = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and result registers; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      work_q     <= '0;
      cnt_q      <= '0;
      binary_q   <= '0;
      invalid_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      binary_q   <= binary_d;
      invalid_q  <= invalid_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy     = (state_q == StShift);
  assign bus.done     = (state_q == StDone);
  assign bus.binary   = binary_q;
  assign bus.invalid  = invalid_q;
  assign bus.overflow = overflow_q;

  // All BCD weight must have drained into the binary part by the final step
  a_bcd_drained: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StShift && last_step) |-> (work_step[WorkW-1:BIN_W] == '0));

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed, table-driven bench for bcd_to_binary.
module tb_bcd_to_binary;
  import bcd_to_binary_pkg::*;

  localparam int unsigned NDig = 3;
  localparam int unsigned BinW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bcd_to_binary_if #(.N_DIGITS(NDig), .BIN_W(BinW)) bus ();

  bcd_to_binary #(.N_DIGITS(NDig), .BIN_W(BinW), .SCORE_MAX(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bcd;
    int          bin;
    int          inv;
    int          ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present b with a one-cycle start, then count busy cycles and done latency
  task automatic do_conv(input logic [11:0] b, output int lat, output int busy_cnt);
    bit seen;
    @(negedge clk);
    bus.bcd   = b;
    bus.start = 1'b1;
    lat       = 0;
    busy_cnt  = 0;
    seen      = 1'b0;
    for (int i = 1; i <= 30 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat  = i;
        seen = 1'b1;
      end
    end
  endtask

  initial begin
    int lat, bcnt, dcnt, val;
    logic [11:0] b;
    bus.start = 1'b0;
    bus.bcd   = '0;

    vecs[0] = '{12'h255, 255, 0, 0};
    vecs[1] = '{12'h999, 999, 0, 1};
    vecs[2] = '{12'h000, 0,   0, 0};
    vecs[3] = '{12'h1A3, 0,   1, 0};
    vecs[4] = '{12'h001, 1,   0, 0};
    vecs[5] = '{12'h256, 256, 0, 1};
    vecs[6] = '{12'h100, 100, 0, 0};
    vecs[7] = '{12'h0F0, 0,   1, 0};
    vecs[8] = '{12'h987, 987, 0, 1};
    vecs[9] = '{12'h09B, 0,   1, 0};

    // Reset state
    #12;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_binary", int'(bus.binary), 0);
    chk("rst_invalid", int'(bus.invalid), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    foreach (vecs[i]) begin
      do_conv(vecs[i].bcd, lat, bcnt);
      chk($sformatf("latency_%03h", vecs[i].bcd), lat, vecs[i].inv ? 1 : 11);
      chk($sformatf("busy_cycles_%03h", vecs[i].bcd), bcnt, vecs[i].inv ? 0 : 10);
      chk($sformatf("binary_%03h", vecs[i].bcd), int'(bus.binary), vecs[i].bin);
      chk($sformatf("invalid_%03h", vecs[i].bcd), int'(bus.invalid), vecs[i].inv);
      chk($sformatf("overflow_%03h", vecs[i].bcd), int'(bus.overflow), vecs[i].ovf);
    end

    // Start during busy is ignored; input changes after capture have no effect
    @(negedge clk);
    bus.bcd   = 12'h128;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bcd   = 12'h999;
    repeat (3) @(negedge clk);
    bus.bcd   = 12'h042;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bcd   = 12'h999;
    lat = 0;
    for (int i = 0; i < 30 && lat == 0; i++) begin
      if (bus.done) lat = 1;
      else @(negedge clk);
    end
    chk("ignored_start_done_seen", lat, 1);
    chk("ignored_start_binary", int'(bus.binary), 128);
    // Back-to-back start in the first IDLE cycle after done
    do_conv(12'h042, lat, bcnt);
    chk("b2b_latency", lat, 11);
    chk("b2b_binary", int'(bus.binary), 42);

    // Previous result is held while a new valid conversion runs
    do_conv(12'h999, lat, bcnt);
    @(negedge clk);
    bus.bcd   = 12'h777;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("hold_binary_during_busy", int'(bus.binary), 999);
    chk("hold_overflow_during_busy", int'(bus.overflow), 1);
    // Abort mid-conversion with reset
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_binary", int'(bus.binary), 0);
    chk("abort_overflow", int'(bus.overflow), 0);
    chk("abort_invalid", int'(bus.invalid), 0);
    dcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    do_conv(12'h077, lat, bcnt);
    chk("post_reset_latency", lat, 11);
    chk("post_reset_binary", int'(bus.binary), 77);

    // Exhaustive sweep of valid three-digit inputs
    for (int h = 0; h < 10; h++) begin
      for (int t = 0; t < 10; t++) begin
        for (int o = 0; o < 10; o++) begin
          b   = {4'(h), 4'(t), 4'(o)};
          val = h * 100 + t * 10 + o;
          do_conv(b, lat, bcnt);
          chk($sformatf("sweep_lat_%03h", b), lat, 11);
          chk($sformatf("sweep_bin_%03h", b), int'(bus.binary), val);
          chk($sformatf("sweep_ovf_%03h", b), int'(bus.overflow), (val > 255) ? 1 : 0);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
